prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter XLEN, default 32, data/address width in bits.
REQ-002 Parameter DEPTH, default 256, instruction words stored; power of two, >= 4.
REQ-003 Parameter MAX_CYCLES, default 8000, run-phase cycle limit; >= 2.
REQ-004 Parameter AW, derived as log2(DEPTH); not user-overridden.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 ld_valid  input  1  loader word valid.
REQ-008 ld_data  input  XLEN  instruction word being loaded.
REQ-009 ld_last  input  1  qualifies final word of program.
REQ-010 ld_ready  output  1  loader may accept a word this cycle.
REQ-011 run  input  1  request to start program execution.
REQ-012 halt_req  input  1  CPU halt indication (e.g. ecall).
REQ-013 clear  input  1  return from HALT to IDLE.
REQ-014 fetch_addr  input  XLEN  CPU byte address for instruction fetch.
REQ-015 fetch_data  output  XLEN  registered fetched word.
REQ-016 fetch_err  output  1  registered misaligned/out-of-range fetch flag.
REQ-017 cpu_hold  output  1  active-high reset for the CPU core.
REQ-018 word_count  output  AW+1  number of words loaded.
REQ-019 cycle_count  output  32  run-phase cycles elapsed.
REQ-020 state  output  2  IDLE=0, READY=1, RUN=2, HALT=3.
REQ-021 done  output  1  program halted by halt_req.
REQ-022 timeout  output  1  program halted by cycle limit.

Function
REQ-023 IDLE: ld_ready=1; handshake (ld_valid & ld_ready) writes ld_data to mem[word_count], word_count increments.
REQ-024 Accepted word with ld_last=1, or accepted word making word_count==DEPTH, moves IDLE->READY next cycle; ld_ready=0 in all states but IDLE.
REQ-025 ld_valid outside IDLE: ignored, no write, word_count unchanged.
REQ-026 READY: run=1 -> RUN next cycle; cycle_count cleared to 0 on entry.
REQ-027 cpu_hold=1 in IDLE, READY, HALT; 0 in RUN (registered, deasserts same edge state becomes RUN).
REQ-028 RUN: cycle_count increments each cycle, saturating at MAX_CYCLES.
REQ-029 RUN with halt_req=1 -> HALT, done=1.
REQ-030 RUN with cycle_count==MAX_CYCLES-1 and halt_req=0 -> HALT, timeout=1.
REQ-031 Simultaneous halt_req and limit: done=1, timeout=0.
REQ-032 HALT: done/timeout/cycle_count held; clear=1 -> IDLE, word_count=0, done=0, timeout=0, cycle_count=0.
REQ-033 run, halt_req, clear ignored in states not named above.
REQ-034 Fetch: every cycle, any state; index = fetch_addr[AW+1:2]; fetch_data/fetch_err valid one cycle after fetch_addr.
REQ-035 fetch_err=1 if fetch_addr[1:0]!=0 or fetch_addr >= 4*DEPTH; fetch_data=0 when fetch_err=1.
REQ-036 Index >= word_count (at sample time) returns fetch_data=0, fetch_err=0; includes same-cycle write to that index.
REQ-037 Memory array not reset; contents beyond word_count never visible.

Reset
REQ-038 reset low, asynchronously: state=IDLE, word_count=0, cycle_count=0, done=0, timeout=0, cpu_hold=1, fetch_data=0, fetch_err=0, ld_ready=1.
REQ-039 Reset mid-LOAD or mid-RUN: identical outcome; previously loaded words unreadable (word_count=0).
REQ-040 First handshake accepted on first rising edge after reset release.

Verification
REQ-041 Load 0x00500093, 0x00100113 (ld_last on 2nd), fetch addr 0 then 4 -> fetch_data 0x00500093, 0x00100113 one cycle later; word_count=2, state=READY.
REQ-042 run=1 in READY, halt_req=1 on 10th RUN cycle -> state=HALT, done=1, timeout=0, cycle_count=9, cpu_hold=1.
REQ-043 MAX_CYCLES=16, no halt_req -> HALT after 16 RUN cycles, timeout=1, cycle_count=15; halt_req on that same cycle -> done=1, timeout=0.
REQ-044 DEPTH=4, five words offered with no ld_last -> four accepted, ld_ready=0 at 5th, word_count=4, state=READY.
REQ-045 fetch_addr 0x2 -> fetch_err=1, data 0; fetch_addr 4*DEPTH -> fetch_err=1; address of unloaded word -> data 0, err 0.
REQ-046 reset low during RUN -> immediately state=IDLE, cpu_hold=1, word_count=0; clear in HALT -> IDLE with flags 0.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader: buffers a streamed program, holds the CPU in reset until run,
// then serves fetches and bounds the run phase by halt_req or a cycle limit.
// Ports: clk, reset (async, active-low), ld_valid/ld_data/ld_last/ld_ready load
//   stream, run/halt_req/clear control, fetch_addr -> fetch_data/fetch_err (one
//   cycle later), cpu_hold, word_count, cycle_count, state, done, timeout.
module prog_loader #(
  parameter int XLEN = 32,
  parameter int DEPTH = 256,
  parameter int MAX_CYCLES = 8000,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ld_valid,
  input  logic [XLEN-1:0] ld_data,
  input  logic            ld_last,
  output logic            ld_ready,
  input  logic            run,
  input  logic            halt_req,
  input  logic            clear,
  input  logic [XLEN-1:0] fetch_addr,
  output logic [XLEN-1:0] fetch_data,
  output logic            fetch_err,
  output logic            cpu_hold,
  output logic [AW:0]     word_count,
  output logic [31:0]     cycle_count,
  output logic [1:0]      state,
  output logic            done,
  output logic            timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    RUN   = 2'd2,
    HALT  = 2'd3
  } st_e;

  localparam logic [XLEN-1:0] ADDR_LIM = XLEN'(4 * DEPTH);
  localparam logic [31:0] CYC_LAST = 32'(MAX_CYCLES - 1);
  localparam logic [31:0] CYC_MAX = 32'(MAX_CYCLES);
  localparam logic [AW:0] WC_LAST = (AW+1)'(DEPTH - 1);

  st_e state_q, state_d;

  logic [XLEN-1:0] mem [DEPTH];

  logic [AW:0] wc_q;
  logic [31:0] cc_q;
  logic        done_q, tmo_q, hold_q;
  logic [XLEN-1:0] fdata_q;
  logic        ferr_q;

  logic        wr_en, go_run, do_clear, at_lim;
  logic        set_done, set_tmo, cc_inc;
  logic [AW-1:0] f_idx;
  logic        f_bad, f_void;

  assign at_lim = (cc_q == CYC_LAST);

  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    go_run   = 1'b0;
    do_clear = 1'b0;
    set_done = 1'b0;
    set_tmo  = 1'b0;
    cc_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ld_valid) begin
          wr_en = 1'b1;
          if (ld_last || wc_q == WC_LAST)
            state_d = READY;
        end
      end
      READY: begin
        if (run) begin
          go_run  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // halt_req wins over the limit on the same cycle
        if (halt_req) begin
          set_done = 1'b1;
          state_d  = HALT;
        end else if (at_lim) begin
          set_tmo = 1'b1;
          state_d = HALT;
        end else begin
          cc_inc = 1'b1;
        end
      end
      HALT: begin
        if (clear) begin
          do_clear = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wc_q   <= '0;
      cc_q   <= '0;
      done_q <= 1'b0;
      tmo_q  <= 1'b0;
      hold_q <= 1'b1;
    end else begin
      hold_q <= (state_d != RUN);
      if (wr_en)
        wc_q <= wc_q + 1'b1;
      else if (do_clear)
        wc_q <= '0;
      if (go_run || do_clear)
        cc_q <= '0;
      else if (cc_inc && cc_q != CYC_MAX)
        cc_q <= cc_q + 32'd1;
      if (set_done) done_q <= 1'b1;
      else if (do_clear) done_q <= 1'b0;
      if (set_tmo) tmo_q <= 1'b1;
      else if (do_clear) tmo_q <= 1'b0;
    end
  end

  // storage is deliberately unreset; word_count gates visibility
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wc_q[AW-1:0]] <= ld_data;
  end

  assign f_idx  = fetch_addr[AW+1:2];
  assign f_bad  = (|fetch_addr[1:0]) || (fetch_addr >= ADDR_LIM);
  // compares against pre-write count, so a same-cycle write reads as empty
  assign f_void = ({1'b0, f_idx} >= wc_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fdata_q <= '0;
      ferr_q  <= 1'b0;
    end else begin
      ferr_q <= f_bad;
      if (f_bad || f_void) fdata_q <= '0;
      else                 fdata_q <= mem[f_idx];
    end
  end

  assign ld_ready    = (state_q == IDLE);
  assign fetch_data  = fdata_q;
  assign fetch_err   = ferr_q;
  assign cpu_hold    = hold_q;
  assign word_count  = wc_q;
  assign cycle_count = cc_q;
  assign state       = state_q;
  assign done        = done_q;
  assign timeout     = tmo_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (DEPTH=4, MAX_CYCLES=16).
// Linear stimulus, immediate-assertion checks, one summary line.
module tb_prog_loader;

  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam int MAXC = 16;
  localparam int AW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            ld_valid;
  logic [XLEN-1:0] ld_data;
  logic            ld_last;
  logic            ld_ready;
  logic            run;
  logic            halt_req;
  logic            clear;
  logic [XLEN-1:0] fetch_addr;
  logic [XLEN-1:0] fetch_data;
  logic            fetch_err;
  logic            cpu_hold;
  logic [AW:0]     word_count;
  logic [31:0]     cycle_count;
  logic [1:0]      state;
  logic            done;
  logic            timeout;

  int total = 0;
  int bad = 0;

  prog_loader #(
    .XLEN(XLEN),
    .DEPTH(DEPTH),
    .MAX_CYCLES(MAXC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ld_valid(ld_valid),
    .ld_data(ld_data),
    .ld_last(ld_last),
    .ld_ready(ld_ready),
    .run(run),
    .halt_req(halt_req),
    .clear(clear),
    .fetch_addr(fetch_addr),
    .fetch_data(fetch_data),
    .fetch_err(fetch_err),
    .cpu_hold(cpu_hold),
    .word_count(word_count),
    .cycle_count(cycle_count),
    .state(state),
    .done(done),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, bit ok);
    total++;
    assert (ok) else begin
      bad++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    ld_valid = 1'b0;
    ld_data = '0;
    ld_last = 1'b0;
    run = 1'b0;
    halt_req = 1'b0;
    clear = 1'b0;
    fetch_addr = '0;
    #2 reset = 1'b0;
    #1;
    check("rst_state", state === 2'd0);
    check("rst_wc", word_count === 3'd0);
    check("rst_cc", cycle_count === 32'd0);
    check("rst_done", done === 1'b0);
    check("rst_tmo", timeout === 1'b0);
    check("rst_hold", cpu_hold === 1'b1);
    check("rst_fdata", fetch_data === 32'd0);
    check("rst_ferr", fetch_err === 1'b0);
    check("rst_ready", ld_ready === 1'b1);
    ticks(2);
    reset = 1'b1;

    ld_valid = 1'b1;
    ld_data = 32'h0050_0093;
    tick();
    check("ld1_wc", word_count === 3'd1);
    check("ld1_state", state === 2'd0);
    ld_data = 32'h0010_0113;
    ld_last = 1'b1;
    tick();
    check("ld2_wc", word_count === 3'd2);
    check("ld2_state", state === 2'd1);
    check("ld2_ready", ld_ready === 1'b0);
    ld_last = 1'b0;
    ld_data = 32'hdead_beef;
    tick();
    check("ign_wc", word_count === 3'd2);
    ld_valid = 1'b0;
    fetch_addr = 32'd0;
    tick();
    check("f0_data", fetch_data === 32'h0050_0093);
    check("f0_err", fetch_err === 1'b0);
    fetch_addr = 32'd4;
    tick();
    check("f4_data", fetch_data === 32'h0010_0113);
    fetch_addr = 32'd2;
    tick();
    check("fmis_err", fetch_err === 1'b1);
    check("fmis_data", fetch_data === 32'd0);
    fetch_addr = 32'd16;
    tick();
    check("foor_err", fetch_err === 1'b1);
    check("foor_data", fetch_data === 32'd0);
    fetch_addr = 32'd8;
    tick();
    check("funl_err", fetch_err === 1'b0);
    check("funl_data", fetch_data === 32'd0);

    run = 1'b1;
    tick();
    run = 1'b0;
    check("run_state", state === 2'd2);
    check("run_hold", cpu_hold === 1'b0);
    check("run_cc0", cycle_count === 32'd0);
    ticks(9);
    check("run_cc9", cycle_count === 32'd9);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("h_state", state === 2'd3);
    check("h_done", done === 1'b1);
    check("h_tmo", timeout === 1'b0);
    check("h_cc", cycle_count === 32'd9);
    check("h_hold", cpu_hold === 1'b1);
    run = 1'b1;
    tick();
    run = 1'b0;
    check("h_keep_state", state === 2'd3);
    check("h_keep_cc", cycle_count === 32'd9);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_state", state === 2'd0);
    check("clr_wc", word_count === 3'd0);
    check("clr_done", done === 1'b0);
    check("clr_cc", cycle_count === 32'd0);

    fetch_addr = 32'd0;
    ld_valid = 1'b1;
    ld_data = 32'h1111_0001;
    tick();
    check("same_cyc_data", fetch_data === 32'd0);
    ld_data = 32'h1111_0002;
    tick();
    check("old_data_gone", fetch_data === 32'h1111_0001);
    ld_data = 32'h1111_0003;
    tick();
    ld_data = 32'h1111_0004;
    tick();
    check("full_wc", word_count === 3'd4);
    check("full_state", state === 2'd1);
    check("full_ready", ld_ready === 1'b0);
    ld_data = 32'h1111_0005;
    fetch_addr = 32'd12;
    tick();
    ld_valid = 1'b0;
    check("fifth_wc", word_count === 3'd4);
    check("f12_data", fetch_data === 32'h1111_0004);

    run = 1'b1;
    tick();
    run = 1'b0;
    ticks(15);
    check("lim_pre_state", state === 2'd2);
    check("lim_pre_cc", cycle_count === 32'd15);
    tick();
    check("lim_state", state === 2'd3);
    check("lim_tmo", timeout === 1'b1);
    check("lim_done", done === 1'b0);
    check("lim_cc", cycle_count === 32'd15);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr2_tmo", timeout === 1'b0);

    ld_valid = 1'b1;
    ld_last = 1'b1;
    ld_data = 32'h0000_0073;
    tick();
    ld_valid = 1'b0;
    ld_last = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0;
    ticks(15);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("both_done", done === 1'b1);
    check("both_tmo", timeout === 1'b0);
    check("both_cc", cycle_count === 32'd15);
    clear = 1'b1;
    tick();
    clear = 1'b0;

    ld_valid = 1'b1;
    ld_last = 1'b1;
    tick();
    ld_valid = 1'b0;
    ld_last = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0;
    ticks(3);
    reset = 1'b0;
    #1;
    check("arst_state", state === 2'd0);
    check("arst_hold", cpu_hold === 1'b1);
    check("arst_wc", word_count === 3'd0);
    check("arst_cc", cycle_count === 32'd0);
    tick();
    reset = 1'b1;
    ld_valid = 1'b1;
    ld_data = 32'h2222_0001;
    tick();
    ld_valid = 1'b0;
    check("post_rst_wc", word_count === 3'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
